// File: rtl/row_sync_arbiter.sv
// Row-level arbiter: round-robin exclusive grant of the shared URAM to one
// core at a time, plus an all-cores-locked barrier that drains the URAM
// before releasing the cores.
module row_sync_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CORES-1:0]         i_core_req,
   input  logic [NUM_CORES-1:0]         i_core_locked,
   output logic [NUM_CORES-1:0]         o_core_grant,
   output logic [$clog2(NUM_CORES)-1:0] o_grant_id,
   output logic                         o_uram_emptied,
   output logic                         o_drain_req,
   input  logic                         i_drain_done,
   output logic                         o_timeout_err
);

   localparam int ID_W = $clog2(NUM_CORES);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BARRIER, S_RELEASE} state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [NUM_CORES-1:0] grant_q, grant_d;
   logic [CNT_W-1:0]     wd_q, wd_d;
   logic                 drain_q, drain_d;
   logic                 emptied_q, emptied_d;
   logic                 err_q, err_d;

   logic [NUM_CORES-1:0] elig;
   logic                 win_found;
   logic [ID_W-1:0]      win_id;
   logic [ID_W:0]        scan;
   logic [ID_W:0]        ptr_inc;
   logic                 wd_hit;

   assign elig = i_core_req & ~i_core_locked;

   // Round-robin search: first eligible core at or above rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan      = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (scan >= (ID_W+1)'(NUM_CORES)) scan = scan - (ID_W+1)'(NUM_CORES);
         if (!win_found && elig[scan[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = scan[ID_W-1:0];
         end
      end
   end

   // Pointer to the core after the current owner, and watchdog expiry.
   always_comb begin
      ptr_inc = {1'b0, id_q} + (ID_W+1)'(1);
      if (ptr_inc == (ID_W+1)'(NUM_CORES)) ptr_inc = '0;
      wd_hit = (TIMEOUT_CYCLES != 0) &&
               (({1'b0, wd_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT_CYCLES));
   end

   // Next-state and next-output logic; all outputs are registered.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      grant_d   = grant_q;
      wd_d      = wd_q;
      drain_d   = drain_q;
      emptied_d = emptied_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            // Barrier wins over pending requests.
            if (&i_core_locked) begin
               state_d = S_BARRIER;
            end else if (win_found) begin
               state_d = S_GRANT;
               id_d    = win_id;
               grant_d = NUM_CORES'(1) << win_id;
               wd_d    = '0;
            end
         end
         S_GRANT: begin
            // Only the owner's req matters; a voluntary drop beats a timeout.
            if (!i_core_req[id_q] || wd_hit) begin
               state_d  = S_IDLE;
               grant_d  = '0;
               id_d     = '0;
               rr_ptr_d = ptr_inc[ID_W-1:0];
               if (i_core_req[id_q]) err_d = 1'b1;
            end else begin
               wd_d = wd_q + CNT_W'(1);
            end
         end
         S_BARRIER: begin
            // Drain cannot be cancelled, so locked bits are ignored here.
            if (i_drain_done) begin
               state_d   = S_RELEASE;
               drain_d   = 1'b0;
               emptied_d = 1'b1;
            end else begin
               drain_d = 1'b1;
            end
         end
         S_RELEASE: begin
            if (i_core_locked == '0) begin
               state_d   = S_IDLE;
               emptied_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         grant_q   <= '0;
         wd_q      <= '0;
         drain_q   <= 1'b0;
         emptied_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         grant_q   <= grant_d;
         wd_q      <= wd_d;
         drain_q   <= drain_d;
         emptied_q <= emptied_d;
         err_q     <= err_d;
      end
   end

   assign o_core_grant   = grant_q;
   assign o_grant_id     = id_q;
   assign o_drain_req    = drain_q;
   assign o_uram_emptied = emptied_q;
   assign o_timeout_err  = err_q;

endmodule

// File: tb/tb_row_sync_arbiter.sv
// Bench for row_sync_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the row.
module tb_row_sync_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] locked = '0;
   logic         done = 1'b0;
   logic [N-1:0] grant;
   logic [1:0]   gid;
   logic         emptied, drain, err;

   int n_chk = 0;
   int n_err = 0;

   row_sync_arbiter #(.NUM_CORES(N), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .clk(clk), .reset(rst), .i_core_req(req), .i_core_locked(locked),
      .o_core_grant(grant), .o_grant_id(gid), .o_uram_emptied(emptied),
      .o_drain_req(drain), .i_drain_done(done), .o_timeout_err(err)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the URAM, how long they have held it, and
   // where the row is in the barrier handshake.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_bar   = 0;
   bit m_drain = 0;
   bit m_emp   = 0;
   bit m_err   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_step();
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_held = 0;
         m_bar = 0; m_drain = 0; m_emp = 0; m_err = 0;
      end else if (m_owner >= 0) begin
         m_held++;
         if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
         end else if (m_held == TO) begin
            m_err = 1;
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
         end
      end else if (m_bar) begin
         if (done) begin m_bar = 0; m_drain = 0; m_emp = 1; end
         else m_drain = 1;
      end else if (m_emp) begin
         if (locked == '0) m_emp = 0;
      end else if (&locked) begin
         m_bar = 1;
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req[c] && !locked[c]) begin
               m_owner = c;
               m_held = 0;
               break;
            end
         end
      end
   endfunction

   task automatic check_outs();
      logic [N-1:0] one;
      logic [N-1:0] eg;
      one = 1;
      eg  = (m_owner >= 0) ? (one << m_owner) : '0;
      chk("grant",   32'(grant),   32'(eg));
      chk("grant_id", 32'(gid),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("drain",   32'(drain),   32'(m_drain));
      chk("emptied", 32'(emptied), 32'(m_emp));
      chk("tmo_err", 32'(err),     32'(m_err));
      chk("onehot",  32'($countones(grant) <= 1), 32'd1);
      chk("drn_emp", 32'(drain & emptied), 32'd0);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         #1;
         check_outs();
      end
   endtask

   initial begin
      // Reset state
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // Single requester holds for 10 cycles
      req = 4'b0100; cyc(10);
      req = 4'b0000; cyc(4);

      // Fairness among 0,1,3 with short drops
      for (int r = 0; r < 6; r++) begin
         req = 4'b1011; cyc(5);
         req = (gid == 2'd0) ? 4'b1010 : (gid == 2'd1) ? 4'b1001 : 4'b0011;
         cyc(1);
      end
      req = '0; cyc(3);

      // Locked exclusion, then all locked from idle
      req = 4'b1010; locked = 4'b0010; cyc(6);
      req = 4'b0010; cyc(4);
      locked = 4'b1111; cyc(5);
      done = 1'b1; cyc(1); done = 1'b0;
      locked = 4'b0111; cyc(3);
      locked = 4'b0000; cyc(3);
      done = 1'b1; cyc(1); done = 1'b0; cyc(2);

      // Watchdog: core 0 never lets go
      req = 4'b0011; cyc(14);
      req = 4'b0000; cyc(3);

      // Reset during grant
      req = 4'b0100; cyc(3);
      rst = 1'b1; cyc(1); rst = 1'b0;
      req = 4'b0101; cyc(4);
      req = 4'b0000; cyc(2);

      // Reset during barrier
      locked = 4'b1111; cyc(4);
      rst = 1'b1; cyc(1); rst = 1'b0;
      locked = 4'b0000; req = 4'b0001; cyc(3);
      req = 4'b0000; cyc(2);

      // Random traffic
      for (int t = 0; t < 4000; t++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3)       locked = '1;
         else if (r < 7)  locked = '0;
         else if (r < 9)  locked = N'($urandom);
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         done = ($urandom_range(0, 5) == 0);
         rst  = ($urandom_range(0, 399) == 0);
         cyc(1);
      end
      rst = 1'b0; done = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
